// File: rtl/sift_fir_mac_pkg.sv
// Shared helpers for the SIFT separable-Gaussian MAC.
//   clog2      : ceiling log2 for elaboration-time width math
//   acc_width  : full-precision accumulator width for a DW x CW x TAPS MAC
//   half_taps  : number of distinct coefficients when symmetric taps are folded
//   HALF       : half_taps() of the default 7-tap configuration
package sift_fir_mac_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Pre-add grows the sample by 1 bit and the zero-extended coefficient adds 1
  // more, so a product is DW+CW+2 bits; summing TAPS of them needs clog2(TAPS).
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + 2 + clog2(taps);
  endfunction

  function automatic int half_taps(input int taps);
    return (taps + 1) / 2;
  endfunction

  localparam int DEF_TAPS = 7;
  localparam int HALF     = (DEF_TAPS + 1) / 2;

endpackage

// File: rtl/sift_fir_mac_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clip to OW bits.
// Ports:
//   sum_i  in  ACCW  signed full-precision sum
//   val_o  out OW    signed rounded/clipped value
//   sat_o  out 1     value was clipped to max or min
module sift_round_sat #(
  parameter int ACCW  = 22,
  parameter int SHIFT = 8,
  parameter int OW    = 12
) (
  input  logic [ACCW-1:0] sum_i,
  output logic [OW-1:0]   val_o,
  output logic            sat_o
);

  // Working width: one guard bit for the rounding add, and wide enough to
  // hold OW-bit limits even when OW exceeds the accumulator.
  localparam int WW = ((ACCW + 1 > OW) ? ACCW + 1 : OW) + 1;

  // (1 << SHIFT) >> 1 is the half-LSB constant and collapses to 0 for SHIFT=0.
  localparam logic signed [WW-1:0] RND  = (WW'(1) << SHIFT) >> 1;
  localparam logic signed [WW-1:0] MAXV = (WW'(1) << (OW - 1)) - WW'(1);
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] rsum;
  logic signed [WW-1:0] shr;

  always_comb begin
    ext  = {{(WW - ACCW){sum_i[ACCW-1]}}, sum_i};
    rsum = ext + RND;
    shr  = rsum >>> SHIFT;
    if (shr > MAXV) begin
      val_o = MAXV[OW-1:0];
      sat_o = 1'b1;
    end else if (shr < MINV) begin
      val_o = MINV[OW-1:0];
      sat_o = 1'b1;
    end else begin
      val_o = shr[OW-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/sift_fir_mac.sv
// 1-D separable-Gaussian MAC for the SIFT detection pipeline.
// A TAPS-deep delay line feeds a free-running 4-stage pipeline:
// pre-add (symmetric fold) -> product -> full-precision sum -> round/clip.
// Ports:
//   iclk    in  1        clock
//   irst_n  in  1        asynchronous active-low reset
//   iDval   in  1        sample valid; shifts the delay line
//   iflush  in  1        line start/end; clears delay line and warm-up count
//   idata   in  DW       signed sample
//   icoef   in  TAPS*CW  unsigned coef k at [k*CW +: CW], tap 0 = newest
//   odata   out OW       signed filtered result (holds when oDval=0)
//   oDval   out 1        one-cycle strobe per result
//   osat    out 1        result was clipped; qualified by oDval
// Handshake: there is no back-pressure. A sample is taken on every edge where
// iDval=1; each result is presented for exactly the one cycle oDval=1 and is
// not repeated, so the consumer must take it then.
module sift_fir_mac
  import sift_fir_mac_pkg::*;
#(
  parameter int TAPS  = 7,
  parameter int DW    = 9,
  parameter int CW    = 8,
  parameter int SHIFT = 8,
  parameter int OW    = 12,
  parameter int SYMM  = 1
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic               iDval,
  input  logic               iflush,
  input  logic [DW-1:0]      idata,
  input  logic [TAPS*CW-1:0] icoef,
  output logic [OW-1:0]      odata,
  output logic               oDval,
  output logic               osat
);

  localparam int ACCW   = acc_width(DW, CW, TAPS);
  localparam int NP     = (SYMM != 0) ? half_taps(TAPS) : TAPS;
  localparam int WCW    = clog2(TAPS + 1);
  localparam int PW     = DW + 1;
  localparam int MW     = DW + CW + 2;

  logic signed [DW-1:0]   tap_q [TAPS];
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic                   prod_d;

  // Per-stage valid bits travel alongside the data registers.
  logic                   tap_v_q, pre_v_q, prd_v_q, sum_v_q;

  logic signed [PW-1:0]   pre_d [NP];
  logic signed [PW-1:0]   pre_q [NP];
  logic signed [MW-1:0]   prd_d [NP];
  logic signed [MW-1:0]   prd_q [NP];
  logic signed [ACCW-1:0] sum_d, sum_q;

  logic [OW-1:0]          rs_val;
  logic                   rs_sat;
  logic [OW-1:0]          odata_q;
  logic                   osat_q, odval_q;

  // Folded configurations leave the upper coefficients unconnected.
  logic                   unused_coef;
  assign unused_coef = ^icoef;

  // Warm-up count of accepted samples since reset/flush, saturating at TAPS.
  // A flush together with a sample starts the new line at 1.
  always_comb begin
    wcnt_d = wcnt_q;
    if (iflush) begin
      wcnt_d = iDval ? WCW'(1) : '0;
    end else if (iDval && (wcnt_q != WCW'(TAPS))) begin
      wcnt_d = wcnt_q + WCW'(1);
    end
    prod_d = iDval && (wcnt_d == WCW'(TAPS));
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wcnt_q  <= '0;
      tap_v_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      tap_v_q <= prod_d;
      if (iflush) begin
        for (int k = 1; k < TAPS; k++) tap_q[k] <= '0;
        tap_q[0] <= iDval ? idata : '0;
      end else if (iDval) begin
        for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
        tap_q[0] <= idata;
      end
    end
  end

  // Pre-add: fold mirrored taps; the centre tap (and every tap when SYMM=0)
  // is only sign-extended so the latency never depends on SYMM.
  for (genvar k = 0; k < NP; k++) begin : g_pre
    if ((SYMM != 0) && (k != TAPS - 1 - k)) begin : g_fold
      assign pre_d[k] = PW'(tap_q[k]) + PW'(tap_q[TAPS-1-k]);
    end else begin : g_pass
      assign pre_d[k] = PW'(tap_q[k]);
    end
  end

  // Coefficients are sampled here; the zero-extension keeps them non-negative
  // inside a signed multiply.
  for (genvar k = 0; k < NP; k++) begin : g_mul
    assign prd_d[k] = MW'(pre_q[k]) * MW'($signed({1'b0, icoef[k*CW +: CW]}));
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NP; k++) begin
      sum_d = sum_d + ACCW'(prd_q[k]);
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pre_v_q <= 1'b0;
      prd_v_q <= 1'b0;
      sum_v_q <= 1'b0;
      sum_q   <= '0;
      for (int k = 0; k < NP; k++) begin
        pre_q[k] <= '0;
        prd_q[k] <= '0;
      end
    end else begin
      pre_v_q <= tap_v_q;
      prd_v_q <= pre_v_q;
      sum_v_q <= prd_v_q;
      sum_q   <= sum_d;
      for (int k = 0; k < NP; k++) begin
        pre_q[k] <= pre_d[k];
        prd_q[k] <= prd_d[k];
      end
    end
  end

  sift_round_sat #(
    .ACCW  (ACCW),
    .SHIFT (SHIFT),
    .OW    (OW)
  ) u_round_sat (
    .sum_i (sum_q),
    .val_o (rs_val),
    .sat_o (rs_sat)
  );

  // odata keeps its last result between strobes; osat is only meaningful
  // alongside oDval and is forced low otherwise.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      odata_q <= '0;
      osat_q  <= 1'b0;
      odval_q <= 1'b0;
    end else begin
      odval_q <= sum_v_q;
      osat_q  <= sum_v_q & rs_sat;
      if (sum_v_q) odata_q <= rs_val;
    end
  end

  assign odata = odata_q;
  assign osat  = osat_q;
  assign oDval = odval_q;

endmodule

// File: tb/tb_sift_fir_mac.sv
// Bench for sift_fir_mac: four configurations share one input stream
//   0 def  : defaults (SHIFT=8, OW=12, SYMM=1)
//   1 nar  : OW=10
//   2 wide : SHIFT=0, OW=20
//   3 ind  : SYMM=0
// A window/convolution model predicts every strobe for all four at once.
module tb_sift_fir_mac;

  localparam int TAPS = 7;
  localparam int DW   = 9;
  localparam int CW   = 8;
  localparam int EW   = 21;

  logic                   iclk   = 1'b0;
  logic                   irst_n = 1'b0;
  logic                   iDval  = 1'b0;
  logic                   iflush = 1'b0;
  logic [DW-1:0]          idata  = '0;
  logic [CW-1:0]          coef  [4][TAPS];
  logic [TAPS*CW-1:0]     icoef [4];

  logic [11:0] od0;
  logic [9:0]  od1;
  logic [19:0] od2;
  logic [11:0] od3;
  logic        dv0, dv1, dv2, dv3;
  logic        st0, st1, st2, st3;
  logic [3:0]  dv, st;
  int          odx [4];

  int p_sh [4] = '{8, 8, 0, 8};
  int p_ow [4] = '{12, 10, 20, 12};
  int p_sy [4] = '{1, 1, 1, 0};

  int                win[$];
  logic [4*EW-1:0]   exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                strobes = 0;
  int                last_od  [4];
  int                last_sat [4];

  typedef struct {
    int fill;
    int last;
    int cdef;
    int e_def;
    int s_def;
    int e_nar;
    int s_nar;
    int e_ind;
  } vec_t;
  vec_t tbl [7];

  always #5 iclk = ~iclk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      icoef[i] = '0;
      for (int k = 0; k < TAPS; k++) icoef[i][k*CW +: CW] = coef[i][k];
    end
  end

  assign dv = {dv3, dv2, dv1, dv0};
  assign st = {st3, st2, st1, st0};

  always_comb begin
    odx[0] = $signed(od0);
    odx[1] = $signed(od1);
    odx[2] = $signed(od2);
    odx[3] = $signed(od3);
  end

  sift_fir_mac #(.TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(8), .OW(12), .SYMM(1)) u_def (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iflush(iflush), .idata(idata),
    .icoef(icoef[0]), .odata(od0), .oDval(dv0), .osat(st0));
  sift_fir_mac #(.TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(8), .OW(10), .SYMM(1)) u_nar (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iflush(iflush), .idata(idata),
    .icoef(icoef[1]), .odata(od1), .oDval(dv1), .osat(st1));
  sift_fir_mac #(.TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(0), .OW(20), .SYMM(1)) u_wide (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iflush(iflush), .idata(idata),
    .icoef(icoef[2]), .odata(od2), .oDval(dv2), .osat(st2));
  sift_fir_mac #(.TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(8), .OW(12), .SYMM(0)) u_ind (
    .iclk(iclk), .irst_n(irst_n), .iDval(iDval), .iflush(iflush), .idata(idata),
    .icoef(icoef[3]), .odata(od3), .oDval(dv3), .osat(st3));

  // Reference: plain convolution of the current window with the effective
  // coefficient of each tap, then round half up, shift and clip.
  function automatic logic [EW-1:0] ref_out(input int i);
    longint s, r, mx, mn, rnd;
    int kk;
    logic sat;
    logic [19:0] lo;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      kk = (p_sy[i] != 0 && k > TAPS - 1 - k) ? TAPS - 1 - k : k;
      s += longint'(win[k]) * longint'(coef[i][kk]);
    end
    rnd = (p_sh[i] > 0) ? (longint'(1) << (p_sh[i] - 1)) : 0;
    r   = (s + rnd) >>> p_sh[i];
    mx  = (longint'(1) << (p_ow[i] - 1)) - 1;
    mn  = -mx - 1;
    sat = 1'b0;
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
    lo = r[19:0];
    return {sat, lo};
  endfunction

  task automatic model_accept(input logic dvi, input logic fl, input int d);
    logic [4*EW-1:0] e;
    if (fl) win.delete();
    if (dvi) begin
      win.push_front(d);
      if (win.size() > TAPS) void'(win.pop_back());
      if (win.size() == TAPS) begin
        for (int i = 0; i < 4; i++) e[i*EW +: EW] = ref_out(i);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input logic dvi, input logic fl, input int d);
    iDval  = dvi;
    iflush = fl;
    idata  = DW'(d);
    model_accept(dvi, fl, d);
    @(posedge iclk);
    #1;
    iDval  = 1'b0;
    iflush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge iclk) begin
    logic [4*EW-1:0] e;
    if (irst_n) begin
      if (dv != 4'b0000 && dv != 4'b1111) begin
        n_tests++;
        n_fail++;
        $display("FAIL dv_agree: got %b expected all equal", dv);
      end
      if (dv[0]) begin
        strobes++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got oDval=1 expected 0 (nothing pending)");
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({st[i], 20'(odx[i])} != e[i*EW +: EW]) begin
              n_fail++;
              $display("FAIL out_inst%0d: got %0d sat %0b expected %0d sat %0b",
                       i, odx[i], st[i], $signed(e[i*EW +: 20]), e[i*EW + 20]);
            end
            last_od[i]  = odx[i];
            last_sat[i] = int'(st[i]);
          end
        end
      end else begin
        n_tests++;
        if (st != 4'b0000) begin
          n_fail++;
          $display("FAIL osat_idle: got %b expected 0000", st);
        end
      end
    end
  end

  initial begin
    int s0;
    int nacc;

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < TAPS; k++) coef[i][k] = '0;

    tbl[0] = '{-256, -256, 255, -1785, 0, -512, 1, -1};
    tbl[1] = '{0,     128,   1,     1, 0,    1, 0,  1};
    tbl[2] = '{0,     127,   1,     0, 0,    0, 0,  0};
    tbl[3] = '{0,    -128,   1,     0, 0,    0, 0,  0};
    tbl[4] = '{0,    -129,   1,    -1, 0,   -1, 0, -1};
    tbl[5] = '{255,   255, 255,  1778, 0,  511, 1,  1};
    tbl[6] = '{100,  -100, 200,   391, 0,  391, 0,  0};

    // Reset values.
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_odata%0d", i), odx[i], 0);
    chk("rst_dval", int'(dv), 0);
    chk("rst_sat", int'(st), 0);
    idle(2);
    irst_n = 1'b1;
    idle(1);

    // Test 1: ramp 1..7 through the binomial-ish kernel, exact latency.
    for (int k = 0; k < TAPS; k++) begin
      coef[0][k] = 8'd1;
      coef[1][k] = 8'd1;
      coef[3][k] = (k == 0) ? 8'd1 : 8'd0;
    end
    coef[2][0] = 8'd1; coef[2][1] = 8'd2; coef[2][2] = 8'd4; coef[2][3] = 8'd8;
    coef[2][4] = 8'd4; coef[2][5] = 8'd2; coef[2][6] = 8'd1;
    step(1'b0, 1'b1, 0);
    s0 = strobes;
    for (int v = 1; v <= 7; v++) step(1'b1, 1'b0, v);
    for (int c = 1; c <= 4; c++) begin
      @(posedge iclk);
      #1;
      chk($sformatf("t1_lat_c%0d", c), int'(dv2), (c == 4) ? 1 : 0);
    end
    idle(3);
    chk("t1_count", strobes - s0, 1);
    chk("t1_value", last_od[2], 88);

    // Test 2: random samples with 1..3 cycle bubbles.
    step(1'b0, 1'b1, 0);
    s0 = strobes;
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b0, rand_sample());
      idle(int'($urandom_range(1, 3)));
    end
    idle(8);
    chk("t2_count", strobes - s0, 20 - 6);

    // Tables: saturation and rounding corner cases.
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < TAPS; k++) begin
        coef[0][k] = CW'(tbl[r].cdef);
        coef[1][k] = CW'(tbl[r].cdef);
      end
      step(1'b0, 1'b1, 0);
      for (int n = 0; n < TAPS - 1; n++) step(1'b1, 1'b0, tbl[r].fill);
      step(1'b1, 1'b0, tbl[r].last);
      idle(6);
      chk($sformatf("tbl%0d_def", r),     last_od[0],  tbl[r].e_def);
      chk($sformatf("tbl%0d_def_sat", r), last_sat[0], tbl[r].s_def);
      chk($sformatf("tbl%0d_nar", r),     last_od[1],  tbl[r].e_nar);
      chk($sformatf("tbl%0d_nar_sat", r), last_sat[1], tbl[r].s_nar);
      chk($sformatf("tbl%0d_ind", r),     last_od[3],  tbl[r].e_ind);
    end

    // Test 5: flush after 9 accepts, in-flight results still emerge.
    step(1'b0, 1'b1, 0);
    s0 = strobes;
    for (int n = 0; n < 9; n++) step(1'b1, 1'b0, rand_sample());
    step(1'b0, 1'b1, 0);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b0, rand_sample());
    idle(8);
    chk("t5_inflight", strobes - s0, 3);
    s0 = strobes;
    step(1'b1, 1'b0, rand_sample());
    idle(6);
    chk("t5_seventh", strobes - s0, 1);
    // Flush together with a sample: that sample is the first of the line.
    s0 = strobes;
    step(1'b1, 1'b1, rand_sample());
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, rand_sample());
    idle(8);
    chk("t5_flushdv_six", strobes - s0, 0);
    step(1'b1, 1'b0, rand_sample());
    idle(6);
    chk("t5_flushdv_seventh", strobes - s0, 1);

    // Test 6: reset mid-stream.
    step(1'b0, 1'b1, 0);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b0, 50 + n);
    irst_n = 1'b0;
    exp_q.delete();
    win.delete();
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("t6_odata%0d", i), odx[i], 0);
    chk("t6_dval", int'(dv), 0);
    @(posedge iclk);
    #1;
    irst_n = 1'b1;
    s0 = strobes;
    idle(8);
    chk("t6_no_stale", strobes - s0, 0);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b0, rand_sample());
    idle(6);
    chk("t6_warm6", strobes - s0, 0);
    step(1'b1, 1'b0, rand_sample());
    idle(6);
    chk("t6_warm7", strobes - s0, 1);

    // Randomised lines with fresh coefficients, bubbles and stray flushes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < TAPS; k++) coef[i][k] = CW'($urandom_range(0, 255));
      step(1'b0, 1'b1, 0);
      s0   = strobes;
      nacc = 0;
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 24) == 0) begin
          step(1'b1, 1'b1, rand_sample());
        end else if ($urandom_range(0, 3) == 0) begin
          step(1'b0, 1'b0, 0);
        end else begin
          step(1'b1, 1'b0, rand_sample());
        end
      end
      idle(8);
    end

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
